// File: rtl/cursor_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cursor_frame_ctrl
// Purpose  : Once per video frame, commits the synchronised mouse position to
//            the cursor-draw stage at the start of vertical blanking. It clamps
//            the position to the visible area, maps it to a board cell and
//            issues one click pulse for each registered button press.
// Revision : 1.0 - initial release
// ============================================================================
module cursor_frame_ctrl #(
    parameter int H_ACTIVE  = 800,
    parameter int V_ACTIVE  = 600,
    parameter int BOARD_X0  = 100,
    parameter int BOARD_Y0  = 100,
    parameter int CELL_SIZE = 40,
    parameter int GRID_N    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] x_in,
    input  logic [11:0] y_in,
    input  logic        left_in,
    input  logic        vblnk,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic [3:0]  cell_x,
    output logic [3:0]  cell_y,
    output logic        cell_valid,
    output logic        click
);

    localparam logic        [11:0] c_X_MAX = 12'(H_ACTIVE - 1);
    localparam logic        [11:0] c_Y_MAX = 12'(V_ACTIVE - 1);
    localparam logic signed [12:0] c_BX0   = 13'(BOARD_X0);
    localparam logic signed [12:0] c_BY0   = 13'(BOARD_Y0);
    localparam logic signed [12:0] c_CELL  = 13'(CELL_SIZE);
    localparam logic signed [12:0] c_SPAN  = 13'(GRID_N * CELL_SIZE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LATCH = 2'd1,
        S_DIV   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [11:0]        r_x_s;
    logic [11:0]        r_y_s;
    logic               r_left_s;
    logic               r_left_q;
    logic               r_vblnk_s;
    logic               r_vblnk_q;
    logic               r_click_pending;
    logic               r_in_board;
    logic signed [12:0] r_rem_x;
    logic signed [12:0] r_rem_y;
    logic [3:0]         r_cnt_x;
    logic [3:0]         r_cnt_y;

    logic               w_vblnk_edge;
    logic               w_left_edge;
    logic [11:0]        w_x_clamp;
    logic [11:0]        w_y_clamp;
    logic signed [12:0] w_rem_x0;
    logic signed [12:0] w_rem_y0;
    logic               w_in_board0;
    logic               w_x_ge;
    logic               w_y_ge;

    assign w_vblnk_edge = r_vblnk_s & ~r_vblnk_q;
    assign w_left_edge  = r_left_s & ~r_left_q;
    assign w_x_clamp    = (r_x_s > c_X_MAX) ? c_X_MAX : r_x_s;
    assign w_y_clamp    = (r_y_s > c_Y_MAX) ? c_Y_MAX : r_y_s;
    // Clamped values are at most 12 bits, so a zero-extended 13-bit signed
    // subtraction cannot overflow and goes negative left of / above the board.
    assign w_rem_x0     = $signed({1'b0, w_x_clamp}) - c_BX0;
    assign w_rem_y0     = $signed({1'b0, w_y_clamp}) - c_BY0;
    assign w_in_board0  = (w_rem_x0 >= 13'sd0) && (w_rem_x0 < c_SPAN) &&
                          (w_rem_y0 >= 13'sd0) && (w_rem_y0 < c_SPAN);
    assign w_x_ge       = (r_rem_x >= c_CELL);
    assign w_y_ge       = (r_rem_y >= c_CELL);

    // Input synchroniser stage plus previous-value copies for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_s     <= '0;
            r_y_s     <= '0;
            r_left_s  <= 1'b0;
            r_left_q  <= 1'b0;
            r_vblnk_s <= 1'b0;
            r_vblnk_q <= 1'b0;
        end else begin
            r_x_s     <= x_in;
            r_y_s     <= y_in;
            r_left_s  <= left_in;
            r_left_q  <= r_left_s;
            r_vblnk_s <= vblnk;
            r_vblnk_q <= r_vblnk_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode. Click is a decoded output valid only in DONE.
    always_comb begin
        w_next_state = r_state;
        click        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_vblnk_edge) begin
                    w_next_state = S_LATCH;
                end
            end
            S_LATCH: begin
                w_next_state = S_DIV;
            end
            S_DIV: begin
                if (!r_in_board || (!w_x_ge && !w_y_ge)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                click        = r_click_pending & r_in_board;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Commit, repeated-subtraction divide and cell publication datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_pos      <= '0;
            y_pos      <= '0;
            cell_x     <= '0;
            cell_y     <= '0;
            cell_valid <= 1'b0;
            r_in_board <= 1'b0;
            r_rem_x    <= '0;
            r_rem_y    <= '0;
            r_cnt_x    <= '0;
            r_cnt_y    <= '0;
        end else begin
            case (r_state)
                S_LATCH: begin
                    x_pos      <= w_x_clamp;
                    y_pos      <= w_y_clamp;
                    r_rem_x    <= w_rem_x0;
                    r_rem_y    <= w_rem_y0;
                    r_cnt_x    <= '0;
                    r_cnt_y    <= '0;
                    r_in_board <= w_in_board0;
                end
                S_DIV: begin
                    if (w_x_ge) begin
                        r_rem_x <= r_rem_x - c_CELL;
                        r_cnt_x <= r_cnt_x + 4'd1;
                    end
                    if (w_y_ge) begin
                        r_rem_y <= r_rem_y - c_CELL;
                        r_cnt_y <= r_cnt_y + 4'd1;
                    end
                end
                S_DONE: begin
                    cell_valid <= r_in_board;
                    cell_x     <= r_in_board ? r_cnt_x : 4'd0;
                    cell_y     <= r_in_board ? r_cnt_y : 4'd0;
                end
                default: begin
                end
            endcase
        end
    end

    // A press edge takes priority over the DONE clear so it survives into
    // the following frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_click_pending <= 1'b0;
        end else if (w_left_edge) begin
            r_click_pending <= 1'b1;
        end else if (r_state == S_DONE) begin
            r_click_pending <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cursor_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cursor_frame_ctrl
// Purpose  : Directed, table-driven self-checking bench for cursor_frame_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cursor_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] x_in;
    logic [11:0] y_in;
    logic        left_in;
    logic        vblnk;
    logic [11:0] x_pos;
    logic [11:0] y_pos;
    logic [3:0]  cell_x;
    logic [3:0]  cell_y;
    logic        cell_valid;
    logic        click;

    int checks    = 0;
    int failures  = 0;
    int click_cnt = 0;

    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        logic [11:0] ex;
        logic [11:0] ey;
        logic [3:0]  cx;
        logic [3:0]  cy;
        logic        v;
    } vec_t;

    vec_t vecs[8];

    cursor_frame_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .x_in       (x_in),
        .y_in       (y_in),
        .left_in    (left_in),
        .vblnk      (vblnk),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .cell_x     (cell_x),
        .cell_y     (cell_y),
        .cell_valid (cell_valid),
        .click      (click)
    );

    always #5 clk = ~clk;

    // Count click-high cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (click === 1'b1) click_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sets position, raises vblnk and returns at cycle N+2 (commit visible).
    task automatic start_frame(input logic [11:0] x, input logic [11:0] y);
        x_in = x;
        y_in = y;
        tick(2);
        vblnk = 1'b1;
        tick(3);
    endtask

    // From N+2 advance to N+13 (worst-case cell result visible), drop vblnk.
    task automatic end_frame();
        tick(11);
        vblnk = 1'b0;
    endtask

    task automatic full_frame(input logic [11:0] x, input logic [11:0] y);
        start_frame(x, y);
        end_frame();
        tick(3);
    endtask

    task automatic chk_cell(input string tag, input int cx, input int cy, input int v);
        chk({tag, "_cell_x"}, int'(cell_x), cx);
        chk({tag, "_cell_y"}, int'(cell_y), cy);
        chk({tag, "_cell_valid"}, int'(cell_valid), v);
    endtask

    initial begin
        int c0;

        vecs[0] = '{x:12'd345,  y:12'd219, ex:12'd345, ey:12'd219, cx:4'd6, cy:4'd2, v:1'b1};
        vecs[1] = '{x:12'd1023, y:12'd700, ex:12'd799, ey:12'd599, cx:4'd0, cy:4'd0, v:1'b0};
        vecs[2] = '{x:12'd100,  y:12'd100, ex:12'd100, ey:12'd100, cx:4'd0, cy:4'd0, v:1'b1};
        vecs[3] = '{x:12'd499,  y:12'd499, ex:12'd499, ey:12'd499, cx:4'd9, cy:4'd9, v:1'b1};
        vecs[4] = '{x:12'd99,   y:12'd200, ex:12'd99,  ey:12'd200, cx:4'd0, cy:4'd0, v:1'b0};
        vecs[5] = '{x:12'd500,  y:12'd200, ex:12'd500, ey:12'd200, cx:4'd0, cy:4'd0, v:1'b0};
        vecs[6] = '{x:12'd139,  y:12'd140, ex:12'd139, ey:12'd140, cx:4'd0, cy:4'd1, v:1'b1};
        vecs[7] = '{x:12'd4095, y:12'd350, ex:12'd799, ey:12'd350, cx:4'd0, cy:4'd0, v:1'b0};

        // Reset with inputs active.
        rst = 1'b1; x_in = 12'd345; y_in = 12'd219; left_in = 1'b1; vblnk = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vblnk = ~vblnk;
            tick(1);
        end
        chk("rst_x_pos", int'(x_pos), 0);
        chk("rst_y_pos", int'(y_pos), 0);
        chk_cell("rst", 0, 0, 0);
        chk("rst_click", int'(click), 0);
        vblnk = 1'b0;
        rst = 1'b0;
        tick(12);
        chk("post_rst_no_click", click_cnt, 0);
        chk("post_rst_x_hold", int'(x_pos), 0);

        // Press pending from release; frame outside board: no pulse, pending cleared.
        full_frame(12'd0, 12'd0);
        chk("outside_no_click", click_cnt, 0);
        chk_cell("outside", 0, 0, 0);
        full_frame(12'd345, 12'd219);
        chk("pending_cleared", click_cnt, 0);
        left_in = 1'b0;
        tick(2);

        // Table-driven commits.
        for (int i = 0; i < 8; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            start_frame(vecs[i].x, vecs[i].y);
            chk({tag, "_x_pos"}, int'(x_pos), int'(vecs[i].ex));
            chk({tag, "_y_pos"}, int'(y_pos), int'(vecs[i].ey));
            end_frame();
            chk_cell(tag, int'(vecs[i].cx), int'(vecs[i].cy), int'(vecs[i].v));
            tick(3);
        end
        chk("table_no_click", click_cnt, 0);

        // Result latency for (345,219): cells appear at N+10 exactly.
        start_frame(12'd345, 12'd219);
        tick(7);
        chk("lat_n9_valid_old", int'(cell_valid), 0);
        tick(1);
        chk_cell("lat_n10", 6, 2, 1);
        end_frame();
        tick(3);

        // Hold between commits.
        full_frame(12'd200, 12'd300);
        chk("hold_commit", int'(x_pos), 200);
        x_in = 12'd300;
        tick(30);
        chk("hold_x_pos", int'(x_pos), 200);
        chk_cell("hold", 2, 5, 1);
        full_frame(12'd300, 12'd300);
        chk("hold_next_commit", int'(x_pos), 300);

        // Click on cell (3,4): press held mid-frame, exactly one pulse.
        full_frame(12'd225, 12'd265);
        c0 = click_cnt;
        left_in = 1'b1;
        tick(6);
        chk("click_not_before_done", click_cnt, c0);
        full_frame(12'd225, 12'd265);
        chk("click_one_pulse", click_cnt, c0 + 1);
        chk_cell("click", 3, 4, 1);
        full_frame(12'd225, 12'd265);
        chk("click_held_no_repeat", click_cnt, c0 + 1);
        left_in = 1'b0;
        tick(2);

        // Reset during DIV: no click, outputs zeroed.
        c0 = click_cnt;
        left_in = 1'b1;
        x_in = 12'd499;
        y_in = 12'd499;
        tick(2);
        vblnk = 1'b1;
        tick(4);
        rst = 1'b1;
        left_in = 1'b0;
        tick(2);
        chk("middiv_rst_x_pos", int'(x_pos), 0);
        chk_cell("middiv_rst", 0, 0, 0);
        vblnk = 1'b0;
        rst = 1'b0;
        tick(20);
        chk("middiv_no_click", click_cnt, c0);
        full_frame(12'd499, 12'd499);
        chk("after_rst_no_click", click_cnt, c0);
        chk_cell("after_rst", 9, 9, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
